// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore FSM driving every datapath strobe for fetch and R-format execute
module control_sequencer #(
    parameter int NREG  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             MDMuxread,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowin,
    output logic             Zhighin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic             ADD,
    output logic             SUB,
    output logic             MUL,
    output logic             DIV,
    output logic             AND,
    output logic             OR,
    output logic             SHR,
    output logic             SHRA,
    output logic             SHL,
    output logic             ROR,
    output logic             ROL,
    output logic             NEG,
    output logic             NOT,
    output logic [NREG-1:0]  reg_in,
    output logic [NREG-1:0]  reg_out,
    output logic             running,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
    state_t state, next;
    logic [4:0] op;
    logic [3:0] ra, rb, rc, sel_o;
    logic alu3, md, un, hlt, done, op_en, drv_o, unused;
    assign op     = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];
    assign unused = ^ir[14:0];
    // add..or occupy the contiguous opcode range 3..11
    assign alu3 = op >= 5'b00011 && op <= 5'b01011;
    assign md   = op == 5'b01111 || op == 5'b10000;
    assign un   = op == 5'b10001 || op == 5'b10010;
    assign hlt  = op == 5'b11011;
    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            instr_count <= '0;
        end else begin
            state <= next;
            if (done) instr_count <= instr_count + 1'b1;
        end
    end
    always_comb begin
        next = state;
        done = 1'b0;
        case (state)
            IDLE: next = start ? T0 : IDLE;
            T0:   next = T1;
            T1:   next = T2;
            T2:   next = T3;
            T3: begin
                next = (alu3 || md || un) ? T4 : hlt ? HALT : T0;
                done = !(alu3 || md || un || hlt);
            end
            T4: begin
                next = un ? T0 : T5;
                done = un;
            end
            T5: begin
                next = md ? T6 : T0;
                done = !md;
            end
            T6: begin
                next = T0;
                done = 1'b1;
            end
            HALT:    next = HALT;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        running   = state != IDLE && state != HALT;
        PCout     = state == T0;
        MARin     = state == T0;
        IncPC     = state == T0;
        PCin      = state == T1;
        MDMuxread = state == T1;
        MDRin     = state == T1;
        MDRout    = state == T2;
        IRin      = state == T2;
        Yin       = state == T3 && (alu3 || md);
        Zlowin    = state == T0 || (state == T4 && (alu3 || md)) || (state == T3 && un);
        Zlowout   = state == T1 || (state == T5 && (alu3 || md)) || (state == T4 && un);
        Zhighin   = state == T4 && md;
        LOin      = state == T5 && md;
        Zhighout  = state == T6;
        HIin      = state == T6;
        op_en     = (state == T4 && (alu3 || md)) || (state == T3 && un);
        ADD       = op_en && op == 5'b00011;
        SUB       = op_en && op == 5'b00100;
        SHR       = op_en && op == 5'b00101;
        SHRA      = op_en && op == 5'b00110;
        SHL       = op_en && op == 5'b00111;
        ROR       = op_en && op == 5'b01000;
        ROL       = op_en && op == 5'b01001;
        AND       = op_en && op == 5'b01010;
        OR        = op_en && op == 5'b01011;
        MUL       = op_en && op == 5'b01111;
        DIV       = op_en && op == 5'b10000;
        NEG       = op_en && op == 5'b10001;
        NOT       = op_en && op == 5'b10010;
        drv_o     = (state == T3 && (alu3 || md || un)) || (state == T4 && (alu3 || md));
        sel_o     = state == T3 ? (md ? ra : rb) : (alu3 ? rc : rb);
        reg_out   = drv_o ? NREG'(1) << sel_o : '0;
        reg_in    = ((state == T5 && alu3) || (state == T4 && un)) ? NREG'(1) << ra : '0;
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench for control_sequencer
`timescale 1ns/1ps
module tb_control_sequencer;
    localparam int CW = 4;
    localparam int PCOUT = 27, MARIN = 26, INCPC = 25, PCIN = 24, MDMUXREAD = 23, MDRIN = 22;
    localparam int MDROUT = 21, IRIN = 20, YIN = 19, ZLOWIN = 18, ZHIGHIN = 17, ZLOWOUT = 16;
    localparam int ZHIGHOUT = 15, HIIN = 14, LOIN = 13;
    logic clock = 0, clear = 1, start = 0;
    logic [31:0] ir = 0;
    logic PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin;
    logic Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    logic [15:0] reg_in, reg_out;
    logic running;
    logic [CW-1:0] instr_count;

    control_sequencer #(.NREG(16), .CNT_W(CW)) dut (
        .clock(clock), .clear(clear), .start(start), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
        .MDMuxread(MDMuxread), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR), .SHR(SHR),
        .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .reg_in(reg_in), .reg_out(reg_out), .running(running), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [27:0]   s;
        logic          run;
        logic [15:0]   ri;
        logic [15:0]   ro;
        logic [CW-1:0] cnt;
    } vec_t;
    typedef struct {
        int    cyc;
        vec_t  v;
        string name;
    } item_t;

    item_t sbq[$];
    item_t it;
    vec_t  got;
    int checks = 0, failures = 0, cyc = 0, exp_cnt = 0, drv = 0;
    bit mon_on = 0, stim_done = 0, reported = 0;
    int ops[$] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18, 0, 1, 2, 12, 13, 14, 26, 31};

    assign got = {PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin, Zlowin,
                  Zhighin, Zlowout, Zhighout, HIin, LOin, ADD, SUB, MUL, DIV, AND, OR,
                  SHR, SHRA, SHL, ROR, ROL, NEG, NOT, running, reg_in, reg_out, instr_count};

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [27:0] b(input int i);
        return 28'(1) << i;
    endfunction

    function automatic int alu_bit(input logic [4:0] op);
        case (op)
            5'b00011: return 12;
            5'b00100: return 11;
            5'b01111: return 10;
            5'b10000: return 9;
            5'b01010: return 8;
            5'b01011: return 7;
            5'b00101: return 6;
            5'b00110: return 5;
            5'b00111: return 4;
            5'b01000: return 3;
            5'b01001: return 2;
            5'b10001: return 1;
            5'b10010: return 0;
            default:  return -1;
        endcase
    endfunction

    function automatic vec_t mk(input logic [27:0] s, input bit run, input int ri, input int ro);
        vec_t v;
        v.s   = s;
        v.run = run;
        v.ri  = ri < 0 ? 16'h0 : 16'(1) << ri;
        v.ro  = ro < 0 ? 16'h0 : 16'(1) << ro;
        v.cnt = CW'(exp_cnt);
        return v;
    endfunction

    task automatic push(input vec_t v, input string name);
        item_t x;
        x.cyc  = cyc;
        x.v    = v;
        x.name = name;
        sbq.push_back(x);
    endtask

    task automatic quiet_cycle(input string name);
        push(mk('0, 0, -1, -1), name);
        @(posedge clock);
        #1;
    endtask

    // Expected per-cycle outputs for one whole instruction, starting in T0
    task automatic run_instr(input logic [31:0] instr, input int abort_at);
        vec_t steps[$];
        logic [4:0] op = instr[31:27];
        int ra = int'(instr[26:23]);
        int rb = int'(instr[22:19]);
        int rc = int'(instr[18:15]);
        int ab = alu_bit(op);
        steps.push_back(mk(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZLOWIN), 1, -1, -1));
        steps.push_back(mk(b(ZLOWOUT) | b(PCIN) | b(MDMUXREAD) | b(MDRIN), 1, -1, -1));
        steps.push_back(mk(b(MDROUT) | b(IRIN), 1, -1, -1));
        if (op == 5'b01111 || op == 5'b10000) begin
            steps.push_back(mk(b(YIN), 1, -1, ra));
            steps.push_back(mk(b(ab) | b(ZLOWIN) | b(ZHIGHIN), 1, -1, rb));
            steps.push_back(mk(b(ZLOWOUT) | b(LOIN), 1, -1, -1));
            steps.push_back(mk(b(ZHIGHOUT) | b(HIIN), 1, -1, -1));
        end else if (op == 5'b10001 || op == 5'b10010) begin
            steps.push_back(mk(b(ab) | b(ZLOWIN), 1, -1, rb));
            steps.push_back(mk(b(ZLOWOUT), 1, ra, -1));
        end else if (ab >= 0) begin
            steps.push_back(mk(b(YIN), 1, -1, rb));
            steps.push_back(mk(b(ab) | b(ZLOWIN), 1, -1, rc));
            steps.push_back(mk(b(ZLOWOUT), 1, ra, -1));
        end else begin
            steps.push_back(mk('0, 1, -1, -1));
        end
        for (int i = 0; i < steps.size(); i++) begin
            ir    = i < 3 ? $urandom : instr;
            start = 1'($urandom_range(0, 1));
            clear = (i == abort_at);
            push(steps[i], $sformatf("op%02h_T%0d", op, i));
            @(posedge clock);
            #1;
            if (i == abort_at) break;
        end
        if (abort_at >= 0) exp_cnt = 0;
        else if (op != 5'b11011) exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    initial begin
        clear = 1;
        start = 0;
        @(posedge clock);
        #1;
        mon_on = 1;
        exp_cnt = 0;
        quiet_cycle("reset");
        clear = 0;
        repeat (5) quiet_cycle("idle_hold");
        start = 1;
        quiet_cycle("idle_start");
        run_instr(32'h28918000, -1);
        run_instr(32'h79100000, -1);
        run_instr(32'hD8000000, -1);
        repeat (4) begin
            start = 1;
            quiet_cycle("halt_hold");
        end
        clear = 1;
        quiet_cycle("halt_clear");
        exp_cnt = 0;
        clear = 0;
        start = 1;
        quiet_cycle("restart");
        run_instr({5'b00000, 4'd3, 4'd4, 4'd5, 15'h1234}, -1);
        run_instr({5'b10001, 4'd9, 4'd10, 4'd0, 15'h0}, -1);
        run_instr({5'b00011, 4'd5, 4'd6, 4'd7, 15'h0}, 4);
        clear = 0;
        start = 0;
        quiet_cycle("abort_idle");
        start = 1;
        quiet_cycle("restart2");
        repeat (50) begin
            logic [31:0] w;
            w = $urandom;
            w[31:27] = 5'(ops[$urandom_range(0, ops.size() - 1)]);
            run_instr(w, -1);
        end
        stim_done = 1;
    end

    always @(negedge clock) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            it = sbq.pop_front();
            checks++;
            if (it.cyc != cyc || got !== it.v) begin
                failures++;
                $display("FAIL %s cyc=%0d/%0d got s=%h run=%b ri=%h ro=%h cnt=%h exp s=%h run=%b ri=%h ro=%h cnt=%h",
                         it.name, cyc, it.cyc, got.s, got.run, got.ri, got.ro, got.cnt,
                         it.v.s, it.v.run, it.v.ri, it.v.ro, it.v.cnt);
            end
        end
        if (mon_on) begin
            drv = $countones(reg_out) + int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout);
            checks++;
            if (drv > 1) begin
                failures++;
                $display("FAIL bus_driver cyc=%0d drivers=%0d allowed<=1", cyc, drv);
            end
        end
        if (stim_done && !reported) begin
            reported = 1;
            checks++;
            if (sbq.size() != 0) begin
                failures++;
                $display("FAIL scoreboard_drain left=%0d expected=0", sbq.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached before end of stimulus");
        $fatal(1, "timeout");
    end
endmodule
